// File: rtl/multi_ranging_ctrl.sv
// Round-robin multi-channel ultrasonic ranging controller: fires one trigger at a
// time, times the echo pulse, converts it to cm and keeps a per-channel distance bank.
module multi_ranging_ctrl #(
    parameter int CH_NUM      = 4,
    parameter int DATA_W      = 16,
    parameter int TRIG_CYC    = 500,
    parameter int CYC_PER_CM  = 2900,
    parameter int MAX_CM      = 400,
    parameter int RISE_TO_CYC = 1_500_000,
    parameter int GAP_CYC     = 3_000_000,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     CLK_50M,
    input  logic                     RST,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        near_thr,
    input  logic [CH_NUM-1:0]        Echo,
    output logic [CH_NUM-1:0]        Trig,
    output logic [DATA_W-1:0]        o_data,
    output logic [CH_W-1:0]          o_ch,
    output logic                     o_valid,
    output logic                     o_timeout,
    output logic [CH_NUM*DATA_W-1:0] dist_all,
    output logic [CH_NUM-1:0]        near
);

    localparam int CNT_MAX0 = (TRIG_CYC > RISE_TO_CYC) ? TRIG_CYC : RISE_TO_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > GAP_CYC) ? CNT_MAX0 : GAP_CYC;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SUB_W    = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'(RISE_TO_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYC_PER_CM - 1);
    localparam logic [DATA_W-1:0] CM_MAX    = DATA_W'(MAX_CM);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH_NUM - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]          r_state;
    logic [CH_W-1:0]     r_ch;
    logic [CNT_W-1:0]    r_cnt;
    logic [SUB_W-1:0]    r_sub;
    logic [DATA_W-1:0]   r_cm;
    logic [CH_NUM-1:0]   r_s1, r_s2, r_s3;
    logic [DATA_W-1:0]   r_data;
    logic [CH_W-1:0]     r_och;
    logic                r_valid;
    logic                r_tmo;
    logic [CH_NUM*DATA_W-1:0] r_dist;
    logic [CH_NUM-1:0]   r_near;

    logic                w_rise, w_fall, w_wrap, w_post, w_post_tmo;
    logic [DATA_W-1:0]   w_cm_next, w_post_val;

    // The measure window runs from the rise-detect cycle to the fall-detect cycle,
    // so the fall cycle's own count is included via w_cm_next.
    always_comb begin
        w_rise     = r_s2[r_ch] & ~r_s3[r_ch];
        w_fall     = ~r_s2[r_ch] & r_s3[r_ch];
        w_wrap     = (r_sub == SUB_LAST);
        w_cm_next  = w_wrap ? r_cm + 1'b1 : r_cm;
        w_post     = 1'b0;
        w_post_tmo = 1'b0;
        case (r_state)
            S_WAIT: if (!w_rise && r_cnt == RISE_LAST) begin
                w_post     = 1'b1;
                w_post_tmo = 1'b1;
            end
            S_MEAS: if (w_cm_next == CM_MAX) begin
                w_post     = 1'b1;
                w_post_tmo = 1'b1;
            end else if (w_fall) begin
                w_post     = 1'b1;
            end
            default: ;
        endcase
        w_post_val = w_post_tmo ? CM_MAX : w_cm_next;
    end

    // Decoded from the async-reset state so Trig drops the instant RST asserts.
    always_comb begin
        Trig = '0;
        if (r_state == S_TRIG) Trig[r_ch] = 1'b1;
    end

    always_ff @(posedge CLK_50M or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_sub   <= '0;
            r_cm    <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
        end else begin
            r_s1 <= Echo;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            case (r_state)
                S_IDLE: if (enable) begin
                    r_state <= S_TRIG;
                    r_cnt   <= '0;
                end
                S_TRIG: if (r_cnt == TRIG_LAST) begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_WAIT: if (w_rise) begin
                    r_state <= S_MEAS;
                    r_sub   <= '0;
                    r_cm    <= '0;
                end else if (w_post) begin
                    r_state <= S_GAP;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_MEAS: if (w_post) begin
                    r_state <= S_GAP;
                    r_cnt   <= '0;
                end else begin
                    r_sub <= w_wrap ? '0 : r_sub + 1'b1;
                    r_cm  <= w_cm_next;
                end
                S_GAP: if (r_cnt == GAP_LAST) begin
                    r_cnt   <= '0;
                    r_ch    <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
                    r_state <= enable ? S_TRIG : S_IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50M or negedge RST) begin
        if (!RST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_och   <= '0;
            r_tmo   <= 1'b0;
            r_dist  <= '0;
            r_near  <= '0;
        end else begin
            r_valid <= w_post;
            if (w_post) begin
                r_data <= w_post_val;
                r_och  <= r_ch;
                r_tmo  <= w_post_tmo;
                for (int unsigned k = 0; k < CH_NUM; k++) begin
                    if (r_ch == CH_W'(k)) begin
                        r_dist[k*DATA_W +: DATA_W] <= w_post_val;
                        r_near[k] <= !w_post_tmo && (w_post_val < near_thr);
                    end
                end
            end
        end
    end

    assign o_data    = r_data;
    assign o_ch      = r_och;
    assign o_valid   = r_valid;
    assign o_timeout = r_tmo;
    assign dist_all  = r_dist;
    assign near      = r_near;

endmodule

// File: tb/tb_multi_ranging_ctrl.sv
// Directed bench for multi_ranging_ctrl: table of shots in round-robin order plus
// hand sequences for async reset and enable deassertion.
module tb_multi_ranging_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic        enable;
    logic [15:0] near_thr;
    logic [3:0]  Echo = '0;
    logic [3:0]  Trig;
    logic [15:0] o_data;
    logic [1:0]  o_ch;
    logic        o_valid;
    logic        o_timeout;
    logic [63:0] dist_all;
    logic [3:0]  near;

    multi_ranging_ctrl #(
        .CH_NUM(4), .DATA_W(16), .TRIG_CYC(5), .CYC_PER_CM(4),
        .MAX_CM(20), .RISE_TO_CYC(50), .GAP_CYC(10)
    ) dut (
        .CLK_50M(clk), .RST(RST), .enable(enable), .near_thr(near_thr),
        .Echo(Echo), .Trig(Trig), .o_data(o_data), .o_ch(o_ch),
        .o_valid(o_valid), .o_timeout(o_timeout), .dist_all(dist_all), .near(near)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int e_start [4] = '{0, 0, 0, 0};
    int e_stop  [4] = '{0, 0, 0, 0};

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) Echo[k] = (cyc >= e_start[k]) && (cyc < e_stop[k]);
    end

    int onehot_err = 0, gap_err = 0, valid_cnt = 0, idle = 0;
    bit idle_track = 0, was_high = 0;

    initial forever begin
        @(negedge clk);
        if ($countones(Trig) > 1) onehot_err++;
        if (o_valid) valid_cnt++;
        if (!RST) begin
            idle_track = 0; was_high = 0; idle = 0;
        end else if (Trig != 0) begin
            if (idle_track && idle < 10) gap_err++;
            idle_track = 0; was_high = 1; idle = 0;
        end else begin
            if (was_high) begin idle_track = 1; was_high = 0; end
            if (idle_track) idle++;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        int          ch;
        int          len;
        int          noise;
        int          drop_at;
        logic [15:0] data;
        logic        tmo;
        logic        nr;
        int          lat;
    } shot_t;

    task automatic run_shot(input shot_t s);
        int t, w, p;
        logic [3:0] onehot;
        onehot = 4'b0001 << s.ch;
        t = 0;
        while (Trig == 0 && t < 300) begin @(negedge clk); t++; end
        chk($sformatf("trig_rise_wait ch%0d", s.ch), t < 300, 1);
        chk($sformatf("trig_sel ch%0d", s.ch), Trig, onehot);
        w = 0;
        while (Trig != 0 && w < 100) begin @(negedge clk); w++; end
        chk($sformatf("trig_width ch%0d", s.ch), w, 5);
        if (s.len > 0) begin
            e_start[s.ch] = cyc + 2;
            e_stop[s.ch]  = cyc + 2 + s.len;
        end
        if (s.noise != 0) begin
            e_start[(s.ch + 2) % 4] = cyc + 5;
            e_stop[(s.ch + 2) % 4]  = cyc + 15;
        end
        p = 0;
        while (!o_valid && p < 400) begin
            @(negedge clk);
            p++;
            if (s.drop_at != 0 && p == s.drop_at) enable = 1'b0;
        end
        chk($sformatf("post_wait ch%0d", s.ch), p < 400, 1);
        if (s.lat != 0) chk($sformatf("post_latency ch%0d", s.ch), p, s.lat);
        chk($sformatf("o_data ch%0d", s.ch), o_data, s.data);
        chk($sformatf("o_ch ch%0d", s.ch), o_ch, s.ch);
        chk($sformatf("o_timeout ch%0d", s.ch), o_timeout, s.tmo);
        chk($sformatf("dist_slice ch%0d", s.ch), dist_all[s.ch*16 +: 16], s.data);
        chk($sformatf("near ch%0d", s.ch), near[s.ch], s.nr);
        @(negedge clk);
        chk($sformatf("valid_pulse ch%0d", s.ch), o_valid, 0);
    endtask

    shot_t tbl[10];
    shot_t hs;
    int    tcount;

    initial begin
        //            ch len noise drop data tmo nr lat
        tbl[0] = '{0,  40, 0, 0, 16'd10, 1'b0, 1'b0, 0};
        tbl[1] = '{1,   0, 1, 0, 16'd20, 1'b1, 1'b0, 50};
        tbl[2] = '{2, 200, 0, 0, 16'd20, 1'b1, 1'b0, 0};
        tbl[3] = '{3,  28, 0, 0, 16'd7,  1'b0, 1'b1, 0};
        tbl[4] = '{0,  42, 0, 0, 16'd10, 1'b0, 1'b0, 0};
        tbl[5] = '{1,  28, 0, 0, 16'd7,  1'b0, 1'b1, 0};
        tbl[6] = '{2,  32, 0, 0, 16'd8,  1'b0, 1'b0, 0};
        tbl[7] = '{3,  31, 0, 0, 16'd7,  1'b0, 1'b1, 0};
        tbl[8] = '{0,  28, 0, 0, 16'd7,  1'b0, 1'b1, 0};
        tbl[9] = '{1,  40, 0, 0, 16'd10, 1'b0, 1'b0, 0};

        RST = 1'b1; enable = 1'b0; near_thr = 16'd8;
        #3 RST = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_trig", Trig, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_data", o_data, 0);
        chk("reset_ch_tmo", {o_ch, o_timeout}, 0);
        chk("reset_bank", {dist_all, near}, 0);

        enable = 1'b1;
        @(negedge clk);
        RST = 1'b1;
        tcount = 0;
        while (Trig == 0 && tcount < 20) begin @(negedge clk); tcount++; end
        chk("first_trig", Trig, 4'b0001);
        @(negedge clk);
        #2 RST = 1'b0;
        #1 chk("async_trig_drop", Trig, 0);
        chk("async_outputs", {o_valid, o_data, dist_all, near}, 0);
        repeat (2) @(negedge clk);
        chk("reset_hold_trig", Trig, 0);
        RST = 1'b1;

        for (int i = 0; i < 10; i++) run_shot(tbl[i]);

        hs = '{2, 40, 0, 20, 16'd10, 1'b0, 1'b0, 0};
        run_shot(hs);
        chk("enable_dropped", enable, 0);
        tcount = 0;
        repeat (80) begin @(negedge clk); if (Trig != 0) tcount++; end
        chk("parked_no_trig", tcount, 0);
        enable = 1'b1;
        hs = '{3, 0, 0, 0, 16'd20, 1'b1, 1'b0, 50};
        run_shot(hs);
        enable = 1'b0;

        chk("final_bank", dist_all, 64'h0014_000A_000A_0007);
        chk("final_near", near, 4'b0001);
        near_thr = 16'd15;
        repeat (3) @(negedge clk);
        #1;
        chk("near_not_reevaluated", near, 4'b0001);
        chk("valid_count", valid_cnt, 12);
        chk("trig_onehot", onehot_err, 0);
        chk("trig_gap", gap_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multi_ranging_ctrl.md
Name: multi_ranging_ctrl

Overview:
- Parametrised multi-channel ultrasonic ranging controller for HC-SR04-style sensors.
- Fires the sensors one at a time in round-robin order, measures each echo pulse width and converts it to centimetres.
- Handles no-echo and over-range timeouts, and keeps a per-channel distance bank plus proximity-alarm flags.
- Sits between the sensor pins and the display/consumer logic, which reads the latest-result stream or the distance bank.

Parameters:
- CH_NUM, 4, number of sensor channels (1..16).
- DATA_W, 16, distance width in cm.
- TRIG_CYC, 500, Trig high time in clocks (10 us at 50 MHz).
- CYC_PER_CM, 2900, clocks of echo per cm (58 us/cm).
- MAX_CM, 400, saturation/over-range distance; must be < 2^DATA_W.
- RISE_TO_CYC, 1_500_000, max clocks from Trig fall to echo rise.
- GAP_CYC, 3_000_000, idle clocks between channel shots.

Ports:
- CLK_50M  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = keep cycling channels.
- near_thr  in  DATA_W  proximity threshold in cm.
- Echo  in  CH_NUM  raw asynchronous echo inputs.
- Trig  out  CH_NUM  trigger outputs; at most one bit high at any time.
- o_data  out  DATA_W  last completed distance in cm.
- o_ch  out  max(1,clog2(CH_NUM))  channel of o_data.
- o_valid  out  1  one-cycle pulse when o_data/o_ch update.
- o_timeout  out  1  qualifies o_data: 1 = no echo or over-range.
- dist_all  out  CH_NUM*DATA_W  distance bank; channel k at bits [k*DATA_W +: DATA_W].
- near  out  CH_NUM  bit k = 1 when channel k's last result was valid and < near_thr.

Behaviour:
- Reset (RST=0, async): all outputs 0, FSM=IDLE, channel pointer 0, counters 0, echo synchronisers 0. Trig drops low immediately, with no wait for a clock edge.
- Echo synchronisation: each Echo bit passes through 2 flops. Rise/fall are detected on the synchronised signal against a third flop, giving 3 cycles of latency from pin to edge.
- FSM states:
  - IDLE: if enable=1, go to TRIG on the next clock.
  - TRIG: Trig[ch]=1 for exactly TRIG_CYC clocks, then go to WAIT_RISE.
  - WAIT_RISE: the rise timer counts from 0. A rising edge on ch goes to MEASURE. If the timer reaches RISE_TO_CYC-1 with no rise, post a timeout result and go to GAP.
  - MEASURE: a sub-counter counts 0..CYC_PER_CM-1; on wrap, cm increments.
    - Falling edge: post cm and go to GAP. Partial cm is truncated.
    - cm reaching MAX_CM: post MAX_CM with timeout and go to GAP immediately; the remaining echo is ignored.
  - GAP: all Trig low for GAP_CYC clocks. Then ch = (ch==CH_NUM-1) ? 0 : ch+1. Go to TRIG if enable=1, else IDLE.
- Posting (in the cycle after the terminating condition):
  - o_valid=1 for 1 cycle.
  - o_data updates; on timeout o_data=MAX_CM.
  - o_ch=ch; o_timeout=flag.
  - dist_all slice ch = o_data.
  - near[ch] = !flag && (o_data < near_thr).
  - All of these hold until the next post.
- Echo on non-selected channels is ignored in every state. An echo already high on entry to WAIT_RISE is not a rise and is ignored until it falls and rises again.
- enable dropping mid-shot: the current shot completes, including posting and GAP. The channel still advances, and the FSM then parks in IDLE.
- near_thr changes take effect only at the next post for each channel; near is not re-evaluated continuously.
- Counters never exceed their terminal values; cm is DATA_W wide and never exceeds MAX_CM.

Test Plan:
- Bench parameters: CH_NUM=4, TRIG_CYC=5, CYC_PER_CM=4, MAX_CM=20, RISE_TO_CYC=50, GAP_CYC=10, near_thr=8.
- Reset behaviour: assert RST=0 mid-TRIG -> Trig=0 within the same cycle; all outputs 0. Release RST with enable=1 -> Trig[0] high for exactly 5 cycles.
- Normal measurement: Echo[0] high for 40 cycles -> one o_valid pulse with o_data=10, o_ch=0, o_timeout=0, dist_all[15:0]=10, near[0]=0. Repeat with 42 cycles -> o_data=10 (truncation). Repeat with 28 cycles -> o_data=7, near[0]=1.
- No-echo timeout: keep Echo[1] low -> o_valid 50 cycles after Trig[1] falls, with o_data=20, o_ch=1, o_timeout=1, near[1]=0.
- Over-range: Echo[2] held high for 200 cycles -> o_valid when cm hits 20, o_data=20, o_timeout=1; the late echo fall produces no extra o_valid.
- Round robin and masking: pulse Echo[3] while ch=1 -> ignored. Sequence check: Trig bits fire in order 0,1,2,3,0, one-hot, with ≥10 idle cycles between shots.
- enable deassert: drop enable during ch=2 MEASURE -> that result still posts, then Trig stays 0. Re-raise enable -> next shot is on channel 3.
